// File: rtl/frame_packer.sv
// frame_packer: ping-pong frame store between the byte-to-word writer and a
// valid/ready word consumer.
//
// Each frame has FAST_WORDS fast words. When sEn was high on the first fast word,
// one slow word follows them. Completed frames go into one of two banks and are
// replayed in completion order, with start, end and slow markers. A frame that
// arrives while both banks hold unread frames is dropped whole and counted.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   fData/fVal        fast word and its single-cycle strobe
//   sData/sVal        slow word and its single-cycle strobe
//   sEn               frame carries a slow word (sampled on the first fast word)
//   oRdy              downstream ready
//   oData/oVal        registered output word and valid
//   oSof/oEof/oSlow   first word / last word / slow word markers, qualified by oVal
//   ovf               sticky: at least one frame dropped since reset
//   dropCnt           saturating dropped-frame count

module frame_packer #(
   parameter int unsigned FAST_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] fData,
   input  logic        fVal,
   input  logic [11:0] sData,
   input  logic        sVal,
   input  logic        sEn,
   input  logic        oRdy,
   output logic [11:0] oData,
   output logic        oVal,
   output logic        oSof,
   output logic        oEof,
   output logic        oSlow,
   output logic        ovf,
   output logic [7:0]  dropCnt
);

   localparam int unsigned Depth    = FAST_WORDS + 1;
   localparam logic [4:0]  LastFast = 5'(FAST_WORDS - 1);
   localparam logic [4:0]  SlowIdx  = 5'(FAST_WORDS);

   typedef enum logic [1:0] {StIdle, StFast, StSlowWait, StDrop} wr_state_e;

   // Frame store, no reset: a word is only read after its bank is marked full.
   logic [11:0] mem_q [2][Depth];

   // Write side state
   wr_state_e   st_q, st_d;
   logic [4:0]  w_idx_q, w_idx_d;
   logic        frm_slow_q, frm_slow_d;
   logic        wb_q, wb_d;
   logic [1:0]  full_q, full_d;
   logic [1:0]  has_slow_q, has_slow_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;

   // Read side state, which also holds the registered outputs
   logic        rb_q, rb_d;
   logic [4:0]  rd_idx_q, rd_idx_d;
   logic [11:0] o_data_q, o_data_d;
   logic        o_val_q, o_val_d;
   logic        o_sof_q, o_sof_d;
   logic        o_eof_q, o_eof_d;
   logic        o_slow_q, o_slow_d;

   // Combinational control
   logic        we;
   logic        w_bank;
   logic [4:0]  w_addr;
   logic [11:0] w_data;
   logic        close;
   logic        close_slow;
   logic        start;
   logic        start_bank;
   logic        release_bank;
   logic [4:0]  rd_last;
   logic [4:0]  rd_nxt;

   //--------------------------------------------------------------------------
   // Read side: present bank rb word by word; hold while not accepted.
   //--------------------------------------------------------------------------
   always_comb begin
      rb_d         = rb_q;
      rd_idx_d     = rd_idx_q;
      o_data_d     = o_data_q;
      o_val_d      = o_val_q;
      o_sof_d      = o_sof_q;
      o_eof_d      = o_eof_q;
      o_slow_d     = o_slow_q;
      release_bank = 1'b0;
      rd_last      = has_slow_q[rb_q] ? SlowIdx : LastFast;
      rd_nxt       = rd_idx_q + 5'd1;

      if (o_val_q) begin
         if (oRdy) begin
            if (o_eof_q) begin
               // Last word taken: free the bank and leave a one-cycle gap.
               release_bank = 1'b1;
               rb_d         = ~rb_q;
               o_val_d      = 1'b0;
               o_sof_d      = 1'b0;
               o_eof_d      = 1'b0;
               o_slow_d     = 1'b0;
            end else begin
               rd_idx_d = rd_nxt;
               o_data_d = mem_q[rb_q][rd_nxt];
               o_sof_d  = 1'b0;
               o_eof_d  = (rd_nxt == rd_last);
               o_slow_d = has_slow_q[rb_q] && (rd_nxt == SlowIdx);
            end
         end
      end else if (full_q[rb_q]) begin
         rd_idx_d = 5'd0;
         o_data_d = mem_q[rb_q][0];
         o_val_d  = 1'b1;
         o_sof_d  = 1'b1;
         o_eof_d  = 1'b0;
         o_slow_d = 1'b0;
      end
   end

   //--------------------------------------------------------------------------
   // Write side FSM
   //--------------------------------------------------------------------------
   always_comb begin
      st_d       = st_q;
      w_idx_d    = w_idx_q;
      frm_slow_d = frm_slow_q;
      wb_d       = wb_q;
      full_d     = full_q;
      has_slow_d = has_slow_q;
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      we         = 1'b0;
      w_bank     = wb_q;
      w_addr     = w_idx_q;
      w_data     = fData;
      close      = 1'b0;
      close_slow = 1'b0;
      start      = 1'b0;
      start_bank = wb_q;

      unique case (st_q)
         StIdle: begin
            if (fVal) begin
               start = 1'b1;
            end
         end
         StFast: begin
            if (fVal) begin
               we      = 1'b1;
               w_idx_d = w_idx_q + 5'd1;
               if (w_idx_q == LastFast) begin
                  if (frm_slow_q) begin
                     st_d = StSlowWait;
                  end else begin
                     close = 1'b1;
                     st_d  = StIdle;
                  end
               end
            end
         end
         StSlowWait: begin
            if (fVal) begin
               // Slow word never came: close short and open the next frame now.
               close = 1'b1;
               start = 1'b1;
            end else if (sVal) begin
               we         = 1'b1;
               w_addr     = SlowIdx;
               w_data     = sData;
               close      = 1'b1;
               close_slow = 1'b1;
               st_d       = StIdle;
            end
         end
         StDrop: begin
            // w_idx == SlowIdx marks the slow-wait position of a dropped frame.
            if (w_idx_q == SlowIdx) begin
               if (fVal) begin
                  start = 1'b1;
               end else if (sVal) begin
                  st_d = StIdle;
               end
            end else if (fVal) begin
               w_idx_d = w_idx_q + 5'd1;
               if ((w_idx_q == LastFast) && !frm_slow_q) begin
                  st_d = StIdle;
               end
            end
         end
         default: st_d = StIdle;
      endcase

      if (release_bank) begin
         full_d[rb_q] = 1'b0;
      end

      // Close and release always target different banks.
      if (close) begin
         full_d[wb_q]     = 1'b1;
         has_slow_d[wb_q] = close_slow;
         wb_d             = ~wb_q;
         start_bank       = ~wb_q;
      end

      if (start) begin
         frm_slow_d = sEn;
         w_idx_d    = 5'd1;
         if (!full_q[start_bank]) begin
            we     = 1'b1;
            w_bank = start_bank;
            w_addr = 5'd0;
            w_data = fData;
            st_d   = StFast;
         end else begin
            st_d  = StDrop;
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end
      end
   end

   //--------------------------------------------------------------------------
   // State registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= StIdle;
         w_idx_q    <= 5'd0;
         frm_slow_q <= 1'b0;
         wb_q       <= 1'b0;
         full_q     <= 2'b00;
         has_slow_q <= 2'b00;
         ovf_q      <= 1'b0;
         drop_cnt_q <= 8'd0;
         rb_q       <= 1'b0;
         rd_idx_q   <= 5'd0;
         o_data_q   <= 12'd0;
         o_val_q    <= 1'b0;
         o_sof_q    <= 1'b0;
         o_eof_q    <= 1'b0;
         o_slow_q   <= 1'b0;
      end else begin
         st_q       <= st_d;
         w_idx_q    <= w_idx_d;
         frm_slow_q <= frm_slow_d;
         wb_q       <= wb_d;
         full_q     <= full_d;
         has_slow_q <= has_slow_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
         rb_q       <= rb_d;
         rd_idx_q   <= rd_idx_d;
         o_data_q   <= o_data_d;
         o_val_q    <= o_val_d;
         o_sof_q    <= o_sof_d;
         o_eof_q    <= o_eof_d;
         o_slow_q   <= o_slow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[w_bank][w_addr] <= w_data;
      end
   end

   assign oData   = o_data_q;
   assign oVal    = o_val_q;
   assign oSof    = o_sof_q;
   assign oEof    = o_eof_q;
   assign oSlow   = o_slow_q;
   assign ovf     = ovf_q;
   assign dropCnt = drop_cnt_q;

endmodule

// File: tb/tb_frame_packer.sv
// Directed self-checking bench for frame_packer (FAST_WORDS = 16).
// Output words are captured as {slow, eof, sof, data} on each accepted transfer.
// They are then compared against hand-built expected frames.

module tb_frame_packer;

   logic        clk;
   logic        rst;
   logic [11:0] fData;
   logic        fVal;
   logic [11:0] sData;
   logic        sVal;
   logic        sEn;
   logic        oRdy;
   logic [11:0] oData;
   logic        oVal;
   logic        oSof;
   logic        oEof;
   logic        oSlow;
   logic        ovf;
   logic [7:0]  dropCnt;

   int checks = 0;
   int errors = 0;

   logic [14:0] got_q [$];
   logic [14:0] exp_q [$];
   logic        hold;
   logic [14:0] hold_w;

   frame_packer #(.FAST_WORDS(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .fData   (fData),
      .fVal    (fVal),
      .sData   (sData),
      .sVal    (sVal),
      .sEn     (sEn),
      .oRdy    (oRdy),
      .oData   (oData),
      .oVal    (oVal),
      .oSof    (oSof),
      .oEof    (oEof),
      .oSlow   (oSlow),
      .ovf     (ovf),
      .dropCnt (dropCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Capture transfers and check that a stalled word stays put.
   always @(negedge clk) begin
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_val", {31'd0, oVal}, 32'd1);
            chk("hold_word", {17'd0, oSlow, oEof, oSof, oData}, {17'd0, hold_w});
         end
         if (oVal && oRdy) got_q.push_back({oSlow, oEof, oSof, oData});
         hold   = oVal && !oRdy;
         hold_w = {oSlow, oEof, oSof, oData};
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_fast(input logic [11:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         fVal  = 1'b1;
         fData = base + 12'(i);
         tick();
      end
      fVal = 1'b0;
   endtask

   task automatic send_slow(input logic [11:0] d);
      sVal  = 1'b1;
      sData = d;
      tick();
      sVal = 1'b0;
   endtask

   task automatic push_word(input logic [11:0] d, input logic sof, input logic eof,
                            input logic slow);
      exp_q.push_back({slow, eof, sof, d});
   endtask

   task automatic push_frame(input logic [11:0] base, input logic with_slow,
                             input logic [11:0] slow_d);
      for (int i = 0; i < 16; i++) begin
         push_word(base + 12'(i), i == 0, (i == 15) && !with_slow, 1'b0);
      end
      if (with_slow) push_word(slow_d, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic compare_out(input string tag);
      int n;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s[%0d]", tag, i), {17'd0, got_q[i]}, {17'd0, exp_q[i]});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst   = 1'b1;
      fData = '0;
      fVal  = 1'b0;
      sData = '0;
      sVal  = 1'b0;
      sEn   = 1'b0;
      oRdy  = 1'b0;
      hold  = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_oData", {20'd0, oData}, 32'd0);
      chk("rst_oVal", {31'd0, oVal}, 32'd0);
      chk("rst_flags", {29'd0, oSof, oEof, oSlow}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_dropCnt", {24'd0, dropCnt}, 32'd0);
      rst  = 1'b0;
      oRdy = 1'b1;
      tick();

      // 1: plain 16-word frame, latency check
      sEn = 1'b0;
      send_fast(12'h010, 16);
      chk("lat_not_yet", {31'd0, oVal}, 32'd0);
      tick();
      chk("lat_oVal", {31'd0, oVal}, 32'd1);
      chk("lat_first", {17'd0, oSlow, oEof, oSof, oData}, {17'd0, 3'b001, 12'h010});
      repeat (30) tick();
      push_frame(12'h010, 1'b0, 12'h000);
      compare_out("plain");

      // 2: frame with slow word
      sEn = 1'b1;
      send_fast(12'h100, 16);
      send_slow(12'h2A4);
      repeat (30) tick();
      push_frame(12'h100, 1'b1, 12'h2A4);
      compare_out("slow");

      // 3: slow word missing, next fVal opens frame 2
      sEn = 1'b1;
      send_fast(12'h200, 16);
      sEn = 1'b0;
      send_fast(12'h111, 1);
      send_fast(12'h301, 15);
      repeat (40) tick();
      push_frame(12'h200, 1'b0, 12'h000);
      push_word(12'h111, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 16; i++) push_word(12'h300 + 12'(i), 1'b0, i == 15, 1'b0);
      compare_out("noslow");

      // 4: stalled consumer, third frame dropped
      oRdy = 1'b0;
      sEn  = 1'b0;
      send_fast(12'h400, 16);
      send_fast(12'h500, 16);
      send_fast(12'h600, 16);
      tick();
      chk("ovf_set", {31'd0, ovf}, 32'd1);
      chk("drop_one", {24'd0, dropCnt}, 32'd1);
      chk("stall_word0", {16'd0, oVal, oSlow, oEof, oSof, oData}, {16'd0, 4'b1001, 12'h400});
      oRdy = 1'b1;
      repeat (50) tick();
      push_frame(12'h400, 1'b0, 12'h000);
      push_frame(12'h500, 1'b0, 12'h000);
      compare_out("ovf");

      // 5: ready toggling every cycle during readout
      sEn = 1'b1;
      send_fast(12'h700, 16);
      send_slow(12'h7AA);
      for (int i = 0; i < 60; i++) begin
         oRdy = ~oRdy;
         tick();
      end
      oRdy = 1'b1;
      tick();
      push_frame(12'h700, 1'b1, 12'h7AA);
      compare_out("toggle");
      chk("ovf_sticky", {31'd0, ovf}, 32'd1);
      chk("drop_hold", {24'd0, dropCnt}, 32'd1);

      // 6: reset mid-frame with an output word in flight
      oRdy = 1'b0;
      sEn  = 1'b0;
      send_fast(12'h900, 16);
      send_fast(12'h800, 8);
      chk("pre_rst_oVal", {31'd0, oVal}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_oVal", {31'd0, oVal}, 32'd0);
      chk("mid_rst_out", {9'd0, oSof, oEof, oSlow, ovf, dropCnt, oData}, 32'd0);
      tick();
      rst = 1'b0;
      compare_out("pre_rst");
      oRdy = 1'b1;
      tick();
      send_fast(12'hA00, 16);
      repeat (30) tick();
      push_frame(12'hA00, 1'b0, 12'h000);
      compare_out("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_packer.md
# frame_packer

Downstream consumer of the byte-to-word writer stage. Collects the per-frame fast words (`fData`/`fVal`) and the optional slow word (`sData`/`sVal`) into a two-bank ping-pong frame store. Replays each completed frame as a contiguous word stream with valid/ready handshake and start/end markers. Frames that arrive while both banks are occupied are dropped whole and counted.

## Interface
- `FAST_WORDS`, 16: fast words per frame (2..31); a bank holds `FAST_WORDS`+1 words.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fData`  in  12  fast word, valid when `fVal`=1.
- `fVal`  in  1  single-cycle fast-word strobe.
- `sData`  in  12  slow word, valid when `sVal`=1.
- `sVal`  in  1  single-cycle slow-word strobe.
- `sEn`  in  1  1 = frames carry a slow word; sampled on the first fast word of each frame.
- `oRdy`  in  1  downstream ready.
- `oData`  out  12  output word.
- `oVal`  out  1  output word valid.
- `oSof`  out  1  first word of frame, qualified by `oVal`.
- `oEof`  out  1  last word of frame, qualified by `oVal`.
- `oSlow`  out  1  current word is the slow word, qualified by `oVal`.
- `ovf`  out  1  sticky: at least one frame dropped since reset.
- `dropCnt`  out  8  dropped-frame count, saturates at 255.

## Operation
- Storage: 2 banks × (`FAST_WORDS`+1) × 12 bit, plus per-bank `full` flag, `len` (`FAST_WORDS` or `FAST_WORDS`+1), `hasSlow`.
- Write FSM states: IDLE, FAST, SLOW_WAIT, DROP.
  - IDLE, `fVal`: if bank `wb` not full, store at index 0, latch `sEn` into `frmSlow`, go to FAST (wIdx=1). If full, go to DROP, set `ovf`, increment `dropCnt`.
  - FAST, `fVal`: store at wIdx, wIdx+1. On word `FAST_WORDS`-1: if `frmSlow`=0, close frame (len=`FAST_WORDS`) and go to IDLE; else go to SLOW_WAIT.
  - SLOW_WAIT, `sVal`: store at index `FAST_WORDS`, close frame (len=`FAST_WORDS`+1, hasSlow=1), go to IDLE.
  - SLOW_WAIT, `fVal`: the slow word is missing. Close the current frame as `FAST_WORDS` long with hasSlow=0, then handle the `fVal` exactly as in IDLE in the same cycle. This targets the other bank.
  - DROP: count fast words (and the slow word if `frmSlow`) without storing. Return to IDLE at the point where the frame would have closed. A `fVal` in the slow-wait position is handled as in SLOW_WAIT.
- Close: set `full[wb]`, toggle `wb`.
- `sVal` in IDLE or FAST is ignored. Simultaneous `fVal`+`sVal`: `fVal` wins, `sVal` ignored.
- Read side: bank `rb` is read out when `full[rb]`=1, words at indices 0..len-1.
  - `oSof` is set on index 0; `oEof` on index len-1; `oSlow` on index `FAST_WORDS` when hasSlow=1.
  - After the `oEof` handshake: clear `full[rb]`, toggle `rb`.
- Frames are emitted strictly in completion order.
- A write close and a read release on the same cycle, on different banks, are both honoured.

## Timing
- Reset values: `oData`=0, `oVal`=`oSof`=`oEof`=`oSlow`=0, `ovf`=0, `dropCnt`=0, both banks empty, `wb`=`rb`=0, write FSM in IDLE.
- All outputs are registered.
- Latency: the `oVal` of the first word rises 2 cycles after the closing strobe cycle (one cycle to set `full`, one to register word 0).
- Handshake: a word transfers on the rising edge where `oVal`&`oRdy`=1.
  - Once asserted, `oData`/`oVal`/flags stay stable until that transfer.
  - The next word is presented the following cycle. Back-to-back throughput is 1 word/clk with `oRdy` held high.
- Between frames, `oVal` drops for at least 1 cycle.
- A bank freed by the `oEof` transfer at edge N is available to a writer strobe at edge N+1 or later.
- `rst` mid-frame: the partial frame is discarded, any in-flight output is aborted, and `oVal` goes low asynchronously.

## Test plan
- `sEn`=0, 16 `fVal` words 0x010..0x01F, `oRdy`=1 → 16 outputs in order, `oSof` on 0x010, `oEof` on 0x01F, `oSlow` never set, first `oVal` 2 clk after the 16th strobe.
- `sEn`=1, 16 fast words, then `sVal` with 0x2A4 → 17 outputs, last = 0x2A4 with `oSlow`=`oEof`=1.
- `sEn`=1, 16 fast words, then `fVal` 0x111 (no `sVal`) → frame 1 emitted as 16 words with no slow flag; 0x111 becomes `oSof` of frame 2.
- `oRdy`=0, three complete frames → frames 1–2 stored, frame 3 dropped, `ovf`=1, `dropCnt`=1. Raise `oRdy` → frames 1 and 2 emitted intact and in order.
- `oRdy` toggling 1/0 each cycle during readout → no word duplicated or lost; `oData` stable while `oVal`=1 and `oRdy`=0.
- `rst` pulse after 8 fast words, then a full 16-word frame → only the second frame is output; all outputs are 0 during reset.
